mul_seq_ctrl: RTL

//  Sequencer for the RV32M multiply unit. It accepts MUL/MULH/MULHSU/MULHU ops over a valid/ready handshake.

---
 rtl/mul_ctrl_pkg.sv | 31 +++
 rtl/mul_shift_add_dp.sv | 48 ++++
 rtl/mul_seq_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mul_ctrl_pkg.sv
// Shared encodings for the RV32M multiply sequencer: op codes, FSM states,
// default widths and the operand-signedness helpers.
package mul_ctrl_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int TAG_W_DEF = 5;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_RUN  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // rs1 is treated as signed for every op except MULHU
    function automatic logic op_a_signed(input logic [1:0] op);
        return op != OP_MULHU;
    endfunction

    // rs2 is treated as signed only for MUL and MULH
    function automatic logic op_b_signed(input logic [1:0] op);
        return (op == OP_MUL) || (op == OP_MULH);
    endfunction

endpackage

// File: rtl/mul_shift_add_dp.sv
// Unsigned iterative shift-add multiplier datapath. The controller loads
// operand magnitudes, steps one multiplier bit per cycle and finally may
// negate the 2*XLEN accumulator for sign correction.
module mul_shift_add_dp
    import mul_ctrl_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic              negate,
    input  logic [XLEN-1:0]   a_mag,
    input  logic [XLEN-1:0]   b_mag,
    output logic              mb_zero,
    output logic [2*XLEN-1:0] acc
);

    logic [2*XLEN-1:0] ma;
    logic [XLEN-1:0]   mb;

    // Operand/accumulator registers: load clears acc, step does one add-shift,
    // negate takes the two's complement of the full-width product.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ma  <= '0;
            mb  <= '0;
            acc <= '0;
        end else if (load) begin
            ma  <= {{XLEN{1'b0}}, a_mag};
            mb  <= b_mag;
            acc <= '0;
        end else if (step) begin
            if (mb[0])
                acc <= acc + ma;
            ma <= ma << 1;
            mb <= mb >> 1;
        end else if (negate) begin
            acc <= ~acc + {{(2*XLEN-1){1'b0}}, 1'b1};
        end
    end

    // High when the multiplier becomes zero after the current step's shift,
    // i.e. no set bits remain above bit 0.
    assign mb_zero = (mb[XLEN-1:1] == '0);

endmodule

// File: rtl/mul_seq_ctrl.sv
// RV32M multiply sequencer: valid/ready request in, magnitude shift-add on
// mul_shift_add_dp, sign fix-up, half select, valid/ready response out.
// Optional build macro MUL_EARLY_OUT_EN: leave RUN as soon as the remaining
// multiplier bits are all zero instead of always running XLEN steps.
module mul_seq_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [XLEN-1:0]  req_a,
    input  logic [XLEN-1:0]  req_b,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [XLEN-1:0]  rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy
);

    localparam int CNT_W = $clog2(XLEN + 1);

    state_t            state, nxt;
    logic [1:0]        op_q;
    logic [TAG_W-1:0]  tag_q;
    logic [XLEN-1:0]   a_q, b_q;
    logic              neg_q;
    logic [CNT_W-1:0]  cnt;

    logic              accept;
    logic              sa, sb;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              dp_load, dp_step, dp_negate;
    logic              mb_zero;
    logic              run_done;
    logic [2*XLEN-1:0] acc;

    assign accept = req_valid && req_ready;

    // Operand signs come from the latched op; |x| of the most negative value
    // wraps to itself, which is the correct unsigned magnitude.
    assign sa    = op_a_signed(op_q) && a_q[XLEN-1];
    assign sb    = op_b_signed(op_q) && b_q[XLEN-1];
    assign a_mag = sa ? (~a_q + {{(XLEN-1){1'b0}}, 1'b1}) : a_q;
    assign b_mag = sb ? (~b_q + {{(XLEN-1){1'b0}}, 1'b1}) : b_q;

`ifdef MUL_EARLY_OUT_EN
    assign run_done = (cnt == CNT_W'(1)) || mb_zero;
`else
    assign run_done = (cnt == CNT_W'(1));
`endif

    mul_shift_add_dp #(.XLEN(XLEN)) u_dp (
        .clk     (clk),
        .rst     (rst),
        .load    (dp_load),
        .step    (dp_step),
        .negate  (dp_negate),
        .a_mag   (a_mag),
        .b_mag   (b_mag),
        .mb_zero (mb_zero),
        .acc     (acc)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= nxt;
    end

    // Next-state logic; flush returns to IDLE from anywhere
    always_comb begin
        nxt = state;
        if (flush) begin
            nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (accept)    nxt = ST_PREP;
                ST_PREP:                nxt = ST_RUN;
                ST_RUN:  if (run_done)  nxt = ST_FIX;
                ST_FIX:                 nxt = ST_DONE;
                ST_DONE: if (rsp_ready) nxt = ST_IDLE;
                default:                nxt = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: handshakes, datapath controls and the selected result half
    always_comb begin
        req_ready = rst && (state == ST_IDLE) && !flush;
        busy      = (state != ST_IDLE);
        rsp_valid = (state == ST_DONE) && !flush;
        dp_load   = (state == ST_PREP) && !flush;
        dp_step   = (state == ST_RUN) && !flush;
        dp_negate = (state == ST_FIX) && neg_q && !flush;
        rsp_data  = '0;
        if (state == ST_DONE)
            rsp_data = (op_q == OP_MUL) ? acc[XLEN-1:0] : acc[2*XLEN-1:XLEN];
    end

    assign rsp_tag = tag_q;

    // Request capture, sign flag and step counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            op_q  <= OP_MUL;
            tag_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            neg_q <= 1'b0;
            cnt   <= '0;
        end else begin
            if (accept) begin
                op_q  <= req_op;
                tag_q <= req_tag;
                a_q   <= req_a;
                b_q   <= req_b;
            end
            if (state == ST_PREP) begin
                neg_q <= sa ^ sb;
                cnt   <= CNT_W'(XLEN);
            end else if (state == ST_RUN) begin
                cnt   <= cnt - CNT_W'(1);
            end
        end
    end

endmodule
